// File: rtl/random_access_memory.sv
// 16 x 8 SAP-1 program/data memory: registered run-mode reads onto an OR-able bus,
// plus a front-panel program mode with edge-detected write button and optional auto-increment.
module random_access_memory #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_output_enable,
  input  logic                  i_prog_mode,
  input  logic [ADDR_WIDTH-1:0] i_prog_address,
  input  logic [DATA_WIDTH-1:0] i_prog_data,
  input  logic                  i_prog_write,
  input  logic                  i_prog_auto_inc,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic [ADDR_WIDTH-1:0] o_prog_address
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] PROG_IDLE  = 2'd1;
  localparam logic [1:0] PROG_WRITE = 2'd2;

  logic [1:0]            state;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] pointer;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  write_edge;

  // The history register updates in every state, so a button held across mode entry never writes.
  assign write_edge     = i_prog_write & ~write_q;
  assign o_prog_address = pointer;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      write_q      <= 1'b0;
      pointer      <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      // NOTE: the array is built from flops with an async clear, because reset must zero every word;
      // a RAM macro could not honour that, so do not expect this to map onto block memory.
      for (int i = 0; i < DEPTH; i++) mem[ADDR_WIDTH'(i)] <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
      write_q      <= i_prog_write;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      case (state)
        RUN: begin
          if (i_output_enable) begin
            o_data       <= mem[i_address];
            o_data_valid <= 1'b1;
          end
          if (i_prog_mode) begin
            state   <= PROG_IDLE;
            pointer <= i_prog_address;
          end
        end
        PROG_IDLE: begin
          if (!i_prog_auto_inc) pointer <= i_prog_address;
          if (!i_prog_mode)     state   <= RUN;
          else if (write_edge)  state   <= PROG_WRITE;
        end
        PROG_WRITE: begin
          // The write always completes, even when program mode drops on this same edge.
          mem[pointer] <= i_prog_data;
          pointer      <= i_prog_auto_inc ? pointer + 1'b1 : i_prog_address;
          state        <= i_prog_mode ? PROG_IDLE : RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_random_access_memory.sv
// Self-checking bench for random_access_memory: directed scenarios plus randomized
// program/read rounds checked against a plain array model of the memory and program pointer.
module tb_random_access_memory;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] i_address;
  logic       i_output_enable;
  logic       i_prog_mode;
  logic [3:0] i_prog_address;
  logic [7:0] i_prog_data;
  logic       i_prog_write;
  logic       i_prog_auto_inc;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic [3:0] o_prog_address;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] model_mem [16];
  logic [3:0] model_ptr;
  logic       model_auto;

  random_access_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .i_address      (i_address),
    .i_output_enable(i_output_enable),
    .i_prog_mode    (i_prog_mode),
    .i_prog_address (i_prog_address),
    .i_prog_data    (i_prog_data),
    .i_prog_write   (i_prog_write),
    .i_prog_auto_inc(i_prog_auto_inc),
    .o_data         (o_data),
    .o_data_valid   (o_data_valid),
    .o_prog_address (o_prog_address)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_ptr = 4'h0;
  endtask

  task automatic idle_inputs();
    i_address       = '0;
    i_output_enable = 1'b0;
    i_prog_mode     = 1'b0;
    i_prog_address  = '0;
    i_prog_data     = '0;
    i_prog_write    = 1'b0;
    i_prog_auto_inc = 1'b0;
  endtask

  // Stimulus only: enter program mode at a switch address.
  task automatic enter_prog(input logic [3:0] addr, input logic auto_inc);
    i_output_enable = 1'b0;
    i_prog_mode     = 1'b1;
    i_prog_address  = addr;
    i_prog_auto_inc = auto_inc;
    model_auto      = auto_inc;
    model_ptr       = addr;
    tick();
  endtask

  task automatic exit_prog();
    i_prog_mode     = 1'b0;
    i_output_enable = 1'b0;
    tick();
    if (!model_auto) model_ptr = i_prog_address;
  endtask

  // Stimulus only: one press/release of the write button, model updated from the rules.
  task automatic prog_pulse(input logic [3:0] addr, input logic [7:0] data);
    i_prog_address = addr;
    i_prog_data    = data;
    i_prog_write   = 1'b1;
    tick();
    i_prog_write = 1'b0;
    tick();
    if (model_auto) begin
      model_mem[model_ptr] = data;
      model_ptr = model_ptr + 4'd1;
    end else begin
      model_mem[addr] = data;
      model_ptr = addr;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (o_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", o_data); end
    n_cmp++;
    if (o_data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_data_valid); end
    n_cmp++;
    if (o_prog_address !== 4'h0) begin n_err++; $display("FAIL reset_ptr: got %h want 0", o_prog_address); end
    reset = 1'b1;
    clear_model();
    model_auto = 1'b0;
    tick();
  endtask

  task automatic test_reset_read();
    logic [3:0] addrs [3];
    addrs = '{4'd0, 4'd7, 4'd15};
    foreach (addrs[k]) begin
      i_address       = addrs[k];
      i_output_enable = 1'b1;
      tick();
      n_cmp++;
      if (o_data !== 8'h00 || o_data_valid !== 1'b1) begin
        n_err++;
        $display("FAIL reset_read[%0d]: got %h/%b want 00/1", addrs[k], o_data, o_data_valid);
      end
    end
    i_output_enable = 1'b0;
    tick();
  endtask

  task automatic test_manual_program();
    logic [3:0] addrs [2];
    enter_prog(4'b0010, 1'b0);
    n_cmp++;
    if (o_prog_address !== 4'b0010) begin n_err++; $display("FAIL prog_entry_ptr: got %h want 2", o_prog_address); end
    // Output enable requested throughout program mode must be ignored.
    i_output_enable = 1'b1;
    i_address       = 4'd0;
    prog_pulse(4'b0010, 8'h1E);
    n_cmp++;
    if (o_data !== 8'h00 || o_data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL prog_bus_quiet: got %h/%b want 00/0", o_data, o_data_valid);
    end
    prog_pulse(4'b1110, 8'hF3);
    n_cmp++;
    if (o_data !== 8'h00 || o_data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL prog_bus_quiet2: got %h/%b want 00/0", o_data, o_data_valid);
    end
    exit_prog();
    addrs = '{4'b0010, 4'b1110};
    foreach (addrs[k]) begin
      i_address       = addrs[k];
      i_output_enable = 1'b1;
      tick();
      n_cmp++;
      if (o_data !== model_mem[addrs[k]] || o_data_valid !== 1'b1) begin
        n_err++;
        $display("FAIL manual_read[%0d]: got %h/%b want %h/1", addrs[k], o_data, o_data_valid, model_mem[addrs[k]]);
      end
    end
    i_output_enable = 1'b0;
    tick();
  endtask

  task automatic test_oe_gating();
    logic oe_seq [3];
    logic [7:0] exp;
    oe_seq = '{1'b1, 1'b0, 1'b1};
    i_address = 4'b1110;
    foreach (oe_seq[k]) begin
      i_output_enable = oe_seq[k];
      tick();
      exp = oe_seq[k] ? model_mem[14] : 8'h00;
      n_cmp++;
      if (o_data !== exp || o_data_valid !== oe_seq[k]) begin
        n_err++;
        $display("FAIL oe_gating[%0d]: got %h/%b want %h/%b", k, o_data, o_data_valid, exp, oe_seq[k]);
      end
    end
    i_output_enable = 1'b0;
    tick();
  endtask

  task automatic test_auto_inc_wrap();
    logic [3:0] addrs [3];
    enter_prog(4'b1110, 1'b1);
    prog_pulse(4'b1110, 8'hA1);
    prog_pulse(4'b1110, 8'hA2);
    prog_pulse(4'b1110, 8'hA3);
    n_cmp++;
    if (o_prog_address !== 4'b0001) begin n_err++; $display("FAIL auto_inc_ptr: got %h want 1", o_prog_address); end
    exit_prog();
    n_cmp++;
    if (o_prog_address !== 4'b0001) begin n_err++; $display("FAIL run_ptr_hold: got %h want 1", o_prog_address); end
    addrs = '{4'd14, 4'd15, 4'd0};
    foreach (addrs[k]) begin
      i_address       = addrs[k];
      i_output_enable = 1'b1;
      tick();
      n_cmp++;
      if (o_data !== model_mem[addrs[k]] || o_data_valid !== 1'b1) begin
        n_err++;
        $display("FAIL auto_read[%0d]: got %h/%b want %h/1", addrs[k], o_data, o_data_valid, model_mem[addrs[k]]);
      end
    end
    i_output_enable = 1'b0;
    i_prog_auto_inc = 1'b0;
    tick();
  endtask

  task automatic test_held_button();
    // Held for 10 cycles: only the first edge writes, a data change while held is ignored.
    enter_prog(4'b0011, 1'b0);
    i_prog_data  = 8'h55;
    i_prog_write = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) i_prog_data = 8'h66;
      tick();
    end
    i_prog_write = 1'b0;
    model_mem[3] = 8'h55;
    tick();
    exit_prog();
    // Button already pressed while entering program mode must not write.
    i_prog_write   = 1'b1;
    i_prog_data    = 8'h99;
    i_prog_address = 4'b0100;
    tick();
    enter_prog(4'b0100, 1'b0);
    tick();
    tick();
    i_prog_write = 1'b0;
    exit_prog();
    for (int a = 2; a <= 4; a++) begin
      i_address       = 4'(a);
      i_output_enable = 1'b1;
      tick();
      n_cmp++;
      if (o_data !== model_mem[a] || o_data_valid !== 1'b1) begin
        n_err++;
        $display("FAIL held_read[%0d]: got %h/%b want %h/1", a, o_data, o_data_valid, model_mem[a]);
      end
    end
    i_output_enable = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int n_wr;
      enter_prog(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      n_wr = $urandom_range(1, 6);
      for (int w = 0; w < n_wr; w++) begin
        i_output_enable = 1'($urandom_range(0, 1));
        prog_pulse(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        n_cmp++;
        if (o_data !== 8'h00 || o_data_valid !== 1'b0 || o_prog_address !== model_ptr) begin
          n_err++;
          $display("FAIL rand_prog[%0d.%0d]: got %h/%b ptr %h want 00/0 ptr %h",
                   r, w, o_data, o_data_valid, o_prog_address, model_ptr);
        end
      end
      exit_prog();
      for (int c = 0; c < 24; c++) begin
        logic [3:0] a;
        logic       oe;
        logic [7:0] exp;
        a  = 4'($urandom_range(0, 15));
        oe = 1'($urandom_range(0, 1));
        i_address       = a;
        i_output_enable = oe;
        tick();
        exp = oe ? model_mem[a] : 8'h00;
        n_cmp++;
        if (o_data !== exp || o_data_valid !== oe || o_prog_address !== model_ptr) begin
          n_err++;
          $display("FAIL rand_read[%0d.%0d] addr %h: got %h/%b ptr %h want %h/%b ptr %h",
                   r, c, a, o_data, o_data_valid, o_prog_address, exp, oe, model_ptr);
        end
      end
      i_output_enable = 1'b0;
      i_prog_auto_inc = 1'b0;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    enter_prog(4'b0101, 1'b0);
    i_prog_address = 4'b0101;
    i_prog_data    = 8'h77;
    i_prog_write   = 1'b1;
    tick();
    // Now in the write state; reset lands before the edge that would commit the write.
    reset = 1'b0;
    #2;
    n_cmp++;
    if (o_prog_address !== 4'h0 || o_data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: ptr %h valid %b want 0/0", o_prog_address, o_data_valid);
    end
    tick();
    idle_inputs();
    reset = 1'b1;
    clear_model();
    model_auto = 1'b0;
    tick();
    n_cmp++;
    if (o_prog_address !== 4'h0) begin n_err++; $display("FAIL mid_reset_ptr: got %h want 0", o_prog_address); end
    for (int a = 0; a < 16; a++) begin
      i_address       = 4'(a);
      i_output_enable = 1'b1;
      tick();
      n_cmp++;
      if (o_data !== 8'h00 || o_data_valid !== 1'b1) begin
        n_err++;
        $display("FAIL mid_reset_read[%0d]: got %h/%b want 00/1", a, o_data, o_data_valid);
      end
    end
    i_output_enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_read();
    test_manual_program();
    test_oe_gating();
    test_auto_inc_wrap();
    test_held_button();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/random_access_memory.md
Name: random_access_memory

Overview:
- 16 x 8 program/data memory for the SAP-1 datapath.
- Consumes the 4-bit address held by the memory address register and returns the addressed byte to the bus on request.
- Provides a manual program mode, driven by front-panel switches, for loading the program before a run.
- Synchronous, registered read path. The internal FSM separates run-time reads from program-mode writes.

Parameters:
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH (16).
- DATA_WIDTH, 8, word width.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state and memory contents.
- i_address  input  ADDR_WIDTH  run-mode read address, driven by the memory address register output.
- i_output_enable  input  1  run-mode read request (bus-out control).
- i_prog_mode  input  1  1 = program mode, 0 = run mode.
- i_prog_address  input  ADDR_WIDTH  program-mode switch address.
- i_prog_data  input  DATA_WIDTH  program-mode switch data.
- i_prog_write  input  1  program-mode write button (level); the block acts on its rising edge only.
- i_prog_auto_inc  input  1  1 = the program pointer auto-increments after each write.
- o_data  output  DATA_WIDTH  read data; 0 whenever o_data_valid = 0, so it can be OR-ed onto the bus.
- o_data_valid  output  1  o_data holds a valid read.
- o_prog_address  output  ADDR_WIDTH  current program pointer, for the front-panel LEDs.

Behaviour:
- Reset (reset = 0, asynchronous):
  - all memory words = 0.
  - o_data = 0, o_data_valid = 0, o_prog_address = 0.
  - state = RUN; write-edge history register = 0.
- FSM states: RUN, PROG_IDLE, PROG_WRITE. Transitions are evaluated at the rising edge:
  - RUN -> PROG_IDLE when i_prog_mode = 1. The pointer loads i_prog_address on this edge.
  - PROG_IDLE -> PROG_WRITE on a write edge (i_prog_write = 1 and history = 0).
  - PROG_WRITE -> PROG_IDLE after exactly one cycle, or -> RUN if i_prog_mode = 0.
  - PROG_IDLE -> RUN when i_prog_mode = 0.
- Read path (RUN only):
  - If i_output_enable = 1 at edge N, then at edge N: o_data <= mem[i_address], o_data_valid <= 1. Outputs are visible after edge N (1-cycle latency).
  - If i_output_enable = 0, then o_data <= 0, o_data_valid <= 0.
  - i_address may change every cycle; each read uses the value sampled at its own edge.
- Program mode (PROG_IDLE / PROG_WRITE):
  - i_output_enable is ignored; o_data = 0, o_data_valid = 0.
  - Write target:
    - i_prog_auto_inc = 0: the pointer tracks i_prog_address every cycle.
    - i_prog_auto_inc = 1: the pointer holds its value except for increments.
  - The write edge is captured in PROG_IDLE. In PROG_WRITE, mem[pointer] <= i_prog_data, using data sampled at the PROG_WRITE edge.
  - Auto-increment: the pointer increments in PROG_WRITE, with wrap 15 -> 0 (modulo 2**ADDR_WIDTH).
  - Holding i_prog_write high performs exactly one write. A new write needs a 0 for at least one cycle first.
  - A write edge arriving while in PROG_WRITE is ignored; the history register still updates.
- Boundary conditions:
  - i_prog_mode falling while in PROG_WRITE: the write completes on that edge, then the state goes to RUN.
  - Returning to RUN: the pointer holds its value, and the first read is governed by i_output_enable at the next edge.
  - A write edge in RUN has no effect. The history register still updates, so a button held across mode entry does not write.
  - Reset asserted mid-write: the write is lost and memory clears.
  - Reset deasserted: the first active edge uses RUN rules.
- The memory array is only written in PROG_WRITE. Run mode never modifies contents.

Test Plan:
- Reset then read: reset = 0 for 2 cycles, release; RUN read with i_output_enable = 1 at addresses 0, 7, 15 -> o_data = 0x00, o_data_valid = 1 one cycle after each request.
- Manual program with auto_inc = 0: prog_mode = 1; write 0x1E to address 0010, then 0xF3 to 1110 (one rising edge each). Leave program mode and read 0010 then 1110 -> 0x1E, 0xF3 with 1-cycle latency. During program mode o_data = 0 and o_data_valid = 0.
- Auto-increment and wrap: prog_mode = 1, i_prog_address = 1110, auto_inc = 1. Pulse write 3 times with data 0xA1, 0xA2, 0xA3 -> mem[14] = 0xA1, mem[15] = 0xA2, mem[0] = 0xA3, final o_prog_address = 0001.
- Held button: i_prog_write held high for 10 cycles with data 0x55 at address 0011 -> exactly one write; a change of data to 0x66 while held does not affect memory; read of 0011 = 0x55.
- Output-enable gating: in RUN, toggle i_output_enable 1, 0, 1 with i_address = 1110 -> o_data = 0xF3, 0x00, 0xF3 and o_data_valid = 1, 0, 1 on successive cycles.
- Mid-operation reset: assert reset in the same cycle as the PROG_WRITE edge for address 0101 -> all memory reads back 0x00, and o_prog_address = 0 after release.
